// File: rtl/mul_loop_param.sv
// -----------------------------------------------------------------------------
// mul_loop_param
//   Iterative shift-add multiplier, parameterised in operand width and in the
//   number of multiplier bits retired per clock (radix). Each operation can be
//   signed (two's complement) or unsigned, and the result is the full 2*WIDTH
//   product. Latency is fixed: ITER = WIDTH/BPC RUN cycles plus one DONE cycle.
//
// Parameters
//   WIDTH   operand width, >= 2
//   BPC     multiplier bits consumed per cycle (1, 2 or 4), must divide WIDTH
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active high
//   start     request, sampled only while busy == 0 (IDLE or DONE)
//   signed_i  1: a_i/b_i are two's complement, 0: unsigned (sampled with start)
//   a_i, b_i  multiplicand / multiplier (sampled with start)
//   p_o       full product, registered, updated only when entering DONE
//   p_hi_o    upper WIDTH bits of p_o
//   busy      high during the ITER RUN cycles
//   done      one-cycle pulse, p_o valid in that cycle
// -----------------------------------------------------------------------------
module mul_loop_param #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] p_o,
    output logic [WIDTH-1:0]   p_hi_o,
    output logic               busy,
    output logic               done
);

    localparam int ITER = WIDTH / BPC;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    // Datapath state. The accumulator holds the partial product in its upper
    // half and the not-yet-consumed multiplier bits in its lower half; every
    // RUN cycle shifts the whole thing right by BPC, so after ITER cycles it
    // contains the complete magnitude product.
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               neg;

    logic load, step, finish;

    // ---------------------------------------------------------------------
    // Operand conditioning: magnitudes and result sign.
    // -2^(WIDTH-1) maps onto 2^(WIDTH-1), which still fits unsigned.
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             sign_in;

    always_comb begin
        a_mag   = (signed_i && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
        b_mag   = (signed_i && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;
        sign_in = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
    end

    // ---------------------------------------------------------------------
    // One radix-2^BPC step: add mcand * slice to the upper half.
    // The partial product is built from BPC shifted copies of mcand rather
    // than a general multiplier.
    // ---------------------------------------------------------------------
    logic [BPC-1:0]       slice;
    logic [WIDTH+BPC-1:0] pp;
    logic [WIDTH+BPC-1:0] sum;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   prod;

    always_comb begin
        slice = acc[BPC-1:0];
        pp    = '0;
        for (int k = 0; k < BPC; k++) begin
            if (slice[k]) begin
                pp = pp + ({{BPC{1'b0}}, mcand} << k);
            end
        end
        sum = {{BPC{1'b0}}, acc[2*WIDTH-1:WIDTH]} + pp;
    end

    generate
        if (BPC < WIDTH) begin : g_shift
            assign acc_next = {sum, acc[WIDTH-1:BPC]};
        end else begin : g_single
            // Whole multiplier consumed in one step: sum is already 2*WIDTH.
            assign acc_next = sum;
        end
    endgenerate

    // Negating a zero magnitude yields zero, so a zero result never comes
    // out negative even when the operand signs differ.
    assign prod = neg ? (~acc_next + 1'b1) : acc_next;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state and control. DONE accepts a new start, giving one
    // result every ITER+1 cycles when issued back to back.
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == LAST) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
        end else if (load) begin
            mcand <= a_mag;
            acc   <= {{WIDTH{1'b0}}, b_mag};
            cnt   <= '0;
            neg   <= sign_in;
        end else if (step) begin
            acc   <= acc_next;
            cnt   <= cnt + 1'b1;
        end
    end

    // Result register: written only on the edge that enters DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_o <= '0;
        end else if (finish) begin
            p_o <= prod;
        end
    end

    assign p_hi_o = p_o[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_mul_loop_param.sv
// -----------------------------------------------------------------------------
// tb_mul_loop_param
//   Directed vectors for an 8-bit radix-2 instance (table plus hand-written
//   sequences for back-to-back issue, ignored starts and mid-operation reset)
//   and a randomised run of a 16-bit radix-16 instance against a behavioural
//   product.
// -----------------------------------------------------------------------------
module tb_mul_loop_param;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // 8-bit, 1 bit per cycle
    logic        start8 = 1'b0, sg8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] p8;
    logic [7:0]  hi8;
    logic        busy8, done8;

    // 16-bit, 4 bits per cycle
    logic        start16 = 1'b0, sg16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] p16;
    logic [15:0] hi16;
    logic        busy16, done16;

    mul_loop_param #(.WIDTH(8), .BPC(1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_i(sg8),
        .a_i(a8), .b_i(b8), .p_o(p8), .p_hi_o(hi8),
        .busy(busy8), .done(done8)
    );

    mul_loop_param #(.WIDTH(16), .BPC(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_i(sg16),
        .a_i(a16), .b_i(b16), .p_o(p16), .p_hi_o(hi16),
        .busy(busy16), .done(done16)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one 8-bit op and wait for done. lat counts negedges after the
    // accepting edge up to the one where done is seen; bcnt counts busy
    // samples before it. Operands are scrambled after acceptance.
    task automatic op8(input logic sg, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] p, output logic [7:0] hi,
                       output int lat, output int bcnt, output logic dn_after);
        @(negedge clk);
        start8 = 1'b1; sg8 = sg; a8 = a; b8 = b;
        @(negedge clk);
        start8 = 1'b0; sg8 = ~sg; a8 = ~a; b8 = a ^ b;
        lat = 1; bcnt = 0;
        while (!done8 && lat < 40) begin
            if (busy8) bcnt++;
            @(negedge clk);
            lat++;
        end
        p  = p8;
        hi = hi8;
        @(negedge clk);
        dn_after = done8;
    endtask

    task automatic op16(input logic sg, input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] p, output logic [15:0] hi, output int lat);
        @(negedge clk);
        start16 = 1'b1; sg16 = sg; a16 = a; b16 = b;
        @(negedge clk);
        start16 = 1'b0; a16 = $urandom; b16 = $urandom;
        lat = 1;
        while (!done16 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        p  = p16;
        hi = hi16;
    endtask

    typedef struct {
        logic        sg;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vt[12];

    initial begin
        logic [15:0] p;
        logic [7:0]  hi;
        logic [31:0] pw;
        logic [15:0] hiw;
        logic        dn;
        int          lat, bcnt;
        int          seen;

        vt[0]  = '{1'b0, 8'h45, 8'h55, 16'h16E9};
        vt[1]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vt[2]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vt[3]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vt[4]  = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        vt[5]  = '{1'b1, 8'h00, 8'h80, 16'h0000};
        vt[6]  = '{1'b1, 8'h7F, 8'hFF, 16'hFF81};
        vt[7]  = '{1'b1, 8'h03, 8'hFB, 16'hFFF1};
        vt[8]  = '{1'b0, 8'hFF, 8'h01, 16'h00FF};
        vt[9]  = '{1'b1, 8'h80, 8'hFF, 16'h0080};
        vt[10] = '{1'b0, 8'hAB, 8'hCD, 16'h88EF};
        vt[11] = '{1'b0, 8'h00, 8'h00, 16'h0000};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_p8",     32'(p8),     32'h0);
        chk("rst_busy8",  32'(busy8),  32'h0);
        chk("rst_done8",  32'(done8),  32'h0);
        chk("rst_p16",    p16,         32'h0);
        chk("rst_busy16", 32'(busy16), 32'h0);
        rst = 1'b0;

        // Table vectors
        for (int i = 0; i < 12; i++) begin
            op8(vt[i].sg, vt[i].a, vt[i].b, p, hi, lat, bcnt, dn);
            chk($sformatf("vec%0d_p", i),    32'(p),    32'(vt[i].p));
            chk($sformatf("vec%0d_hi", i),   32'(hi),   32'(vt[i].p[15:8]));
            chk($sformatf("vec%0d_lat", i),  lat,       32'd9);
            chk($sformatf("vec%0d_busy", i), bcnt,      32'd8);
            chk($sformatf("vec%0d_pulse", i), 32'(dn),  32'h0);
        end

        // Start during busy is ignored; start in DONE is accepted
        @(negedge clk);
        start8 = 1'b1; sg8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        @(negedge clk);
        lat = 2;
        start8 = 1'b1; sg8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        @(negedge clk);
        lat = 3;
        start8 = 1'b0;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("ign_lat", lat, 32'd9);
        chk("ign_p", 32'(p8), 32'h03A8);
        start8 = 1'b1; sg8 = 1'b0; a8 = 8'h0F; b8 = 8'h0E;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 40) begin
            if (lat == 4) chk("b2b_hold", 32'(p8), 32'h03A8);
            @(negedge clk);
            lat++;
        end
        chk("b2b_gap", lat, 32'd9);
        chk("b2b_p", 32'(p8), 32'h00D2);

        // Reset in the third RUN cycle aborts the op
        @(negedge clk);
        start8 = 1'b1; sg8 = 1'b0; a8 = 8'h45; b8 = 8'h55;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy8), 32'h0);
        chk("abort_done", 32'(done8), 32'h0);
        chk("abort_p",    32'(p8),    32'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) seen++;
        end
        chk("abort_no_done", seen, 32'd0);
        op8(1'b1, 8'hFE, 8'h05, p, hi, lat, bcnt, dn);
        chk("after_abort_p",   32'(p), 32'hFFF6);
        chk("after_abort_lat", lat,    32'd9);

        // 16-bit, radix 16: random ops against a behavioural product
        for (int i = 0; i < 1000; i++) begin
            logic               s;
            logic [15:0]        a, b;
            logic signed [31:0] sa, sb;
            logic [31:0]        exp;
            s = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 9))
                0: a = 16'h8000;
                1: b = 16'h8000;
                2: a = 16'h0000;
                3: b = 16'hFFFF;
                4: begin a = 16'h8000; b = 16'h8000; end
                default: ;
            endcase
            sa  = {{16{a[15]}}, a};
            sb  = {{16{b[15]}}, b};
            exp = s ? 32'(sa * sb) : ({16'h0, a} * {16'h0, b});
            op16(s, a, b, pw, hiw, lat);
            chk($sformatf("r16_%0d_p", i),   pw,  exp);
            chk($sformatf("r16_%0d_lat", i), lat, 32'd5);
            if (i % 100 == 0) chk($sformatf("r16_%0d_hi", i), 32'(hiw), 32'(exp[31:16]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
